// File: rtl/dct_pkg.sv
// Shared constants, read-FSM state type and JPEG zigzag scan table.
package dct_pkg;

  localparam int unsigned DCT_COEF_W    = 11;
  localparam int unsigned DCT_BLK_COEFS = 64;
  localparam int unsigned DCT_BLK_W     = DCT_COEF_W * DCT_BLK_COEFS;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } rd_state_e;

  // Zigzag position -> raster position (row*8 + col) for an 8x8 block.
  localparam logic [5:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz_to_raster(input logic [5:0] zz_idx);
    return ZZ_TABLE[zz_idx];
  endfunction

endpackage

// File: rtl/dct_zigzag_rom.sv
// Combinational zigzag index to raster index lookup.
module dct_zigzag_rom
  import dct_pkg::*;
(
  input  logic [5:0] zz_idx,
  output logic [5:0] raster_idx
);

  // Pure table lookup, no state.
  always_comb begin
    raster_idx = zz_to_raster(zz_idx);
  end

endmodule

// File: rtl/dct_coef_zigzag_reader.sv
// Double-buffers 8x8 DCT blocks and streams each one in JPEG zigzag order
// over a valid/ready interface; blocks arriving with both buffers busy are
// dropped and flagged in a sticky overflow bit.
module dct_coef_zigzag_reader
  import dct_pkg::*;
#(
  parameter int unsigned COEF_W    = DCT_COEF_W,
  parameter int unsigned BLK_COEFS = DCT_BLK_COEFS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COEF_W*BLK_COEFS-1:0]   coef_in,
  input  logic                          coef_valid,
  output logic signed [COEF_W-1:0]      out_coef,
  output logic [5:0]                    out_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sob,
  output logic                          out_eob,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [1:0]                    blk_pending
);

  localparam int unsigned BlkW    = COEF_W * BLK_COEFS;
  localparam logic [5:0]  LastIdx = 6'(BLK_COEFS - 1);

  logic [BlkW-1:0] blk_q [2];
  logic [BlkW-1:0] rd_blk;
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [1:0]      full_q, full_d;
  rd_state_e       state_q, state_d;
  logic [5:0]      k_q, k_d;
  logic            ovf_q, ovf_d;
  logic            xfer, last_xfer, capture, drop;
  logic [5:0]      raster_idx;

  dct_zigzag_rom u_zigzag_rom (
    .zz_idx     (k_q),
    .raster_idx (raster_idx)
  );

  // Handshake and capture decisions; an entry finishing its last transfer
  // this cycle is already free for an incoming block.
  always_comb begin
    xfer      = (state_q == StStream) && out_ready;
    last_xfer = xfer && (k_q == LastIdx);
    capture   = coef_valid && (!full_q[wr_sel_q] || (last_xfer && (wr_sel_q == rd_sel_q)));
    drop      = coef_valid && !capture;
  end

  // Next-state for pointers, full flags, scan index, read FSM and overflow.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    k_d      = k_q;
    state_d  = state_q;
    ovf_d    = ovf_q;

    if (xfer) begin
      k_d = last_xfer ? 6'd0 : k_q + 6'd1;
    end
    if (last_xfer) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    // Applied after the release so a same-cycle refill leaves the entry full.
    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    unique case (state_q)
      StIdle:   if (full_q[rd_sel_q]) state_d = StStream;
      StStream: if (last_xfer && !full_q[~rd_sel_q]) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A drop wins over a simultaneous clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= 2'b00;
      k_q      <= 6'd0;
      state_q  <= StIdle;
      ovf_q    <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      k_q      <= k_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
    end
  end

  // Block storage; contents are don't-care until the matching full flag is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      blk_q[wr_sel_q] <= coef_in;
    end
  end

  // Output decode from the entry being streamed.
  always_comb begin
    rd_blk      = blk_q[rd_sel_q];
    out_valid   = (state_q == StStream);
    out_idx     = k_q;
    out_sob     = out_valid && (k_q == 6'd0);
    out_eob     = out_valid && (k_q == LastIdx);
    out_coef    = out_valid ? $signed(rd_blk[int'(raster_idx) * COEF_W +: COEF_W]) : '0;
    overflow    = ovf_q;
    blk_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  end

endmodule

// File: tb/tb_dct_coef_zigzag_reader.sv
// Bench for dct_coef_zigzag_reader: block-queue reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_dct_coef_zigzag_reader;

  localparam int CW = 11;
  localparam int NC = 64;
  localparam int BW = CW * NC;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [BW-1:0]        coef_in = '0;
  logic                 coef_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 ovf_clr = 1'b0;
  logic signed [CW-1:0] out_coef;
  logic [5:0]           out_idx;
  logic                 out_valid, out_sob, out_eob, overflow;
  logic [1:0]           blk_pending;

  dct_coef_zigzag_reader dut (
    .clk         (clk),
    .rst         (rst),
    .coef_in     (coef_in),
    .coef_valid  (coef_valid),
    .out_coef    (out_coef),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sob     (out_sob),
    .out_eob     (out_eob),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .blk_pending (blk_pending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Zigzag order derived by walking the anti-diagonals of the 8x8 grid.
  int zz [64];
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
      end
    end
  endfunction

  // Reference model: FIFO of at most two blocks, head offered while active.
  logic [BW-1:0] m_q [$];
  bit m_active = 1'b0;
  bit m_ovf = 1'b0;
  int m_k = 0;
  bit m_xf, m_dn, m_hn, m_dr;
  int m_nb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_k      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_xf = m_active && out_ready;
      m_dn = m_xf && (m_k == NC - 1);
      m_nb = m_q.size();
      m_hn = (m_nb >= 2);
      if (m_dn) void'(m_q.pop_front());
      m_dr = coef_valid && (m_q.size() >= 2);
      if (coef_valid && !m_dr) m_q.push_back(coef_in);
      if (m_dr) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (m_active) begin
        if (m_dn) m_active = m_hn;
      end else begin
        m_active = (m_nb >= 1);
      end
      if (m_xf) m_k = (m_k + 1) % NC;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int log_q [$];
  int log_cyc [$];
  logic                 p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b0;
  logic [5:0]           p_idx = '0;
  logic signed [CW-1:0] p_coef = '0;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [BW-1:0] hb;
    int e_coef;
    if (!rst) begin
      check("rst_valid", out_valid, 0);
      check("rst_idx", out_idx, 0);
      check("rst_coef", out_coef, 0);
      check("rst_sob", out_sob, 0);
      check("rst_eob", out_eob, 0);
      check("rst_ovf", overflow, 0);
      check("rst_pending", blk_pending, 0);
    end else begin
      check("valid", out_valid, m_active);
      check("pending", blk_pending, m_q.size());
      check("overflow", overflow, m_ovf);
      if (m_active && m_q.size() > 0) begin
        hb     = m_q[0];
        e_coef = $signed(hb[zz[m_k] * CW +: CW]);
        check("idx", out_idx, m_k);
        check("coef", out_coef, e_coef);
        check("sob", out_sob, (m_k == 0) ? 1 : 0);
        check("eob", out_eob, (m_k == NC - 1) ? 1 : 0);
      end
      if (p_rst && p_valid && !p_ready) begin
        check("stall_valid", out_valid, 1);
        check("stall_idx", out_idx, p_idx);
        check("stall_coef", out_coef, p_coef);
      end
      if (out_valid && out_ready) begin
        log_q.push_back(int'(out_coef));
        log_cyc.push_back(cyc);
      end
    end
    p_valid = out_valid;
    p_ready = out_ready;
    p_rst   = rst;
    p_idx   = out_idx;
    p_coef  = out_coef;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [BW-1:0] b);
    coef_in    = b;
    coef_valid = 1'b1;
    tick();
    coef_valid = 1'b0;
  endtask

  function automatic logic [BW-1:0] mk_block(input int base);
    logic [BW-1:0] b;
    for (int n = 0; n < NC; n++) b[n * CW +: CW] = CW'(base + n);
    return b;
  endfunction

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int i = 0;
    while (log_q.size() < n && i < budget) begin tick(); i++; end
    check(name, log_q.size(), n);
  endtask

  task automatic wait_idle();
    int i = 0;
    out_ready = 1'b1;
    while ((out_valid || blk_pending != 2'd0) && i < 500) begin tick(); i++; end
    check("idle_reached", out_valid, 0);
  endtask

  task automatic wait_idx(input int idx);
    int i = 0;
    while (!(out_valid && out_idx == 6'(idx)) && i < 300) begin tick(); i++; end
    check("reach_idx", out_idx, idx);
  endtask

  logic [BW-1:0] sblk;

  initial begin
    build_zz();
    check("zz_2", zz[2], 8);
    check("zz_3", zz[3], 16);
    check("zz_10", zz[10], 32);
    check("zz_61", zz[61], 55);
    check("zz_63", zz[63], 63);

    repeat (3) tick();
    rst = 1'b1;

    // Ramp block, always ready.
    out_ready = 1'b1;
    clear_log();
    strobe(mk_block(0));
    check("lat_gap_valid", out_valid, 0);
    check("lat_pending", blk_pending, 1);
    tick();
    check("lat_first_valid", out_valid, 1);
    check("lat_first_sob", out_sob, 1);
    wait_log(64, 200, "ramp_count");
    if (log_q.size() >= 64) begin
      check("ramp_0", log_q[0], 0);
      check("ramp_2", log_q[2], 8);
      check("ramp_3", log_q[3], 16);
      check("ramp_10", log_q[10], 32);
      check("ramp_63", log_q[63], 63);
      check("ramp_span", log_cyc[63] - log_cyc[0], 63);
    end
    wait_idle();

    // Signed extremes.
    for (int n = 0; n < NC; n++) sblk[n * CW +: CW] = 11'h400;
    sblk[CW-1:0] = 11'h3ff;
    clear_log();
    strobe(sblk);
    wait_log(64, 200, "signed_count");
    if (log_q.size() >= 64) begin
      check("signed_0", log_q[0], 1023);
      check("signed_1", log_q[1], -1024);
      check("signed_63", log_q[63], -1024);
    end
    wait_idle();

    // Three blocks while stalled: third is dropped.
    out_ready = 1'b0;
    clear_log();
    strobe(mk_block(100));
    check("ovf_pend_1", blk_pending, 1);
    repeat (7) tick();
    strobe(mk_block(200));
    check("ovf_pend_2", blk_pending, 2);
    repeat (7) tick();
    strobe(mk_block(300));
    check("ovf_pend_3", blk_pending, 2);
    check("ovf_set", overflow, 1);
    out_ready = 1'b1;
    wait_log(128, 400, "ovf_count");
    if (log_q.size() >= 128) begin
      check("ovf_b1_first", log_q[0], 100);
      check("ovf_b1_last", log_q[63], 163);
      check("ovf_b2_first", log_q[64], 200);
      check("ovf_b2_last", log_q[127], 263);
      check("ovf_no_bubble", log_cyc[127] - log_cyc[0], 127);
    end
    repeat (4) tick();
    check("ovf_extra_xfers", log_q.size(), 128);
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    wait_idle();

    // Random backpressure.
    clear_log();
    out_ready = 1'b0;
    strobe(mk_block(400));
    for (int i = 0; i < 600 && log_q.size() < 64; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b0;
    check("rand_count", log_q.size(), 64);
    if (log_q.size() >= 64) begin
      for (int k = 0; k < NC; k++) check("rand_order", log_q[k], 400 + zz[k]);
    end
    wait_idle();

    // Refill of the freed entry on the final transfer, other entry full.
    out_ready = 1'b0;
    clear_log();
    strobe(mk_block(500));
    tick();
    strobe(mk_block(600));
    check("edge_pend_pre", blk_pending, 2);
    out_ready = 1'b1;
    wait_idx(63);
    strobe(mk_block(700));
    check("edge_no_ovf", overflow, 0);
    check("edge_pend", blk_pending, 2);
    wait_log(192, 400, "edge_count");
    if (log_q.size() >= 192) begin
      check("edge_b2_first", log_q[64], 600);
      check("edge_b3_first", log_q[128], 700);
      check("edge_b3_last", log_q[191], 763);
      check("edge_no_bubble", log_cyc[191] - log_cyc[0], 191);
    end
    wait_idle();

    // Reset mid-stream.
    out_ready = 1'b1;
    clear_log();
    strobe(mk_block(800));
    wait_idx(30);
    rst = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_pending", blk_pending, 0);
    check("mrst_idx", out_idx, 0);
    tick();
    tick();
    rst = 1'b1;
    clear_log();
    strobe(mk_block(900));
    wait_idx(0);
    check("mrst_restart_coef", out_coef, 900);
    wait_log(64, 200, "mrst_count");
    if (log_q.size() >= 64) check("mrst_last", log_q[63], 963);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct_coef_zigzag_reader.md
DCT_COEF_ZIGZAG_READER -- requirements
Module: dct_coef_zigzag_reader

Interface
REQ-001 Parameter COEF_W, default 11, coefficient width in bits (signed, two's complement).
REQ-002 Parameter BLK_COEFS, default 64, coefficients per 8x8 block.
REQ-003 clk  input  1  rising-edge clock; sole clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 coef_in  input  704  8x8 coefficient block from the DCT core; coefficient (row r, col c) at bits [(r*8+c)*11 +: 11].
REQ-006 coef_valid  input  1  one-cycle strobe from the DCT done output; coef_in is valid in this cycle.
REQ-007 out_coef  output  11  signed coefficient being offered.
REQ-008 out_idx  output  6  zigzag position (0..63) of out_coef.
REQ-009 out_valid  output  1  out_coef/out_idx hold a valid coefficient.
REQ-010 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-011 out_sob / out_eob  output  1 each  high with zigzag index 0 / 63 respectively.
REQ-012 overflow  output  1  sticky: a block was dropped.
REQ-013 ovf_clr  input  1  synchronous clear of overflow.
REQ-014 blk_pending  output  2  number of buffered blocks not yet fully streamed (0..2).

Function
REQ-015 Two-entry ping-pong block buffer; write pointer wr_sel and read pointer rd_sel; full[1:0] flags.
REQ-016 coef_valid with at least one entry free: capture coef_in into entry wr_sel on that edge, set full[wr_sel], toggle wr_sel.
REQ-017 coef_valid with both entries full: block dropped, buffer unchanged, overflow set next cycle.
REQ-018 overflow stays high until ovf_clr or reset; ovf_clr and a drop in the same cycle leave overflow set.
REQ-019 Read FSM states: IDLE (out_valid=0), STREAM (out_valid=1).
REQ-020 IDLE -> STREAM on the edge after full[rd_sel] becomes set; minimum latency coef_valid to first out_valid = 1 cycle.
REQ-021 In STREAM: out_coef = entry[rd_sel] coefficient at raster position ZZ[k], where k = out_idx and ZZ is the standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,...,55,62,63).
REQ-022 Each transfer increments k; all outputs hold stable while out_valid && !out_ready.
REQ-023 Transfer at k=63: clear full[rd_sel], toggle rd_sel, k wraps to 0; stay in STREAM with no bubble if the other entry is full, else go to IDLE.
REQ-024 Capture into the entry being freed in the same cycle as its k=63 transfer counts it free (no drop).
REQ-025 A capture never alters the entry being streamed.
REQ-026 blk_pending = popcount(full).
REQ-027 Coefficients pass unmodified; no saturation or rounding.

Reset
REQ-028 While rst low: out_valid=0, out_idx=0, out_coef=0, out_sob=0, out_eob=0, overflow=0, blk_pending=0, wr_sel=rd_sel=0, FSM=IDLE.
REQ-029 Reset mid-stream discards both buffered blocks; buffer data contents need not be cleared.
REQ-030 First capture possible on the first rising edge after rst deasserts.

Structure
REQ-031 Shared package dct_pkg holds COEF_W, BLK_COEFS, the 704-bit block width constant and the zigzag index table/function.
REQ-032 One sub-module, dct_zigzag_rom: combinational 6-bit zigzag index -> 6-bit raster index.
REQ-033 Target 150-300 lines of RTL; no memories beyond the two 704-bit registers.

Verification
REQ-034 Ramp block (raster coef n = n), out_ready=1 -> out_coef sequence 0,1,8,16,9,2,3,10,...,62,63 on 64 consecutive cycles; sob at first, eob at last.
REQ-035 Signed block (all -1024, raster 0 = +1023) -> first out_coef +1023, then 63 x -1024, sign preserved.
REQ-036 Three coef_valid strobes 8 cycles apart, out_ready=0 -> blk_pending 1,2,2; overflow=1 after third; then out_ready=1 -> exactly blocks 1 and 2 stream, 128 transfers, no bubble between them.
REQ-037 out_ready toggled randomly at 50% -> out_coef/out_idx stable while stalled; total 64 transfers per block, order per REQ-021.
REQ-038 New block strobed in the same cycle as the k=63 transfer with other entry full -> no overflow, blk_pending stays 2.
REQ-039 rst low at k=30 -> out_valid=0 and blk_pending=0 immediately; next block after release streams from out_idx 0.
